// File: rtl/i2c_regbank.sv
// i2c_regbank: configuration register bank fed by the i2c_slave byte stream.
//
// The first data byte after an addressed START sets the register pointer.
// Further written bytes update registers with pointer auto-increment, and
// read requests return register contents with auto-increment. A pointer
// byte outside the bank drops the rest of the frame and flags err.
//
// Optional feature macro: I2C_REGBANK_SHADOW_EN
//   defined   : writes and reads use shadow registers. STOP copies the shadow
//               into the live bank in one cycle and pulses wr_strobe for
//               every register written since the last commit.
//   undefined : writes update the live bank (reg_out) directly.
//
// Parameters
//   NREGS   number of 8-bit registers (power of two, 2..128)
//   RSTVAL  reset value of every register
// Ports
//   clk, rst     clock, synchronous active-high reset
//   frame_start  pulse: START / repeated START with our address acknowledged
//   frame_stop   pulse: STOP detected
//   rx_byte      received data byte, qualified by rx_valid
//   rx_valid     pulse: data byte complete
//   tx_req       pulse: slave shifter needs the next read byte
//   tx_byte      read data, held until the next tx_valid
//   tx_valid     pulse: tx_byte updated
//   reg_out      live register contents, register i at [8i+7:8i]
//   wr_strobe    per-register pulse: register i changed on reg_out
//   err          pointer out of range in the current frame
module i2c_regbank #(
    parameter int          NREGS  = 8,
    parameter logic [7:0]  RSTVAL = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 frame_stop,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_valid,
    input  logic                 tx_req,
    output logic [7:0]           tx_byte,
    output logic                 tx_valid,
    output logic [NREGS*8-1:0]   reg_out,
    output logic [NREGS-1:0]     wr_strobe,
    output logic                 err
);

    localparam int             PW      = $clog2(NREGS);
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);
    localparam logic [8:0]     NREGS_9 = 9'(NREGS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PTR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [7:0]       regs_q [NREGS];
    logic [7:0]       regs_d [NREGS];
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_valid_q, tx_valid_d;
    logic [NREGS-1:0] wr_strobe_q, wr_strobe_d;
    logic             err_q, err_d;
`ifdef I2C_REGBANK_SHADOW_EN
    logic [7:0]       shadow_q [NREGS];
    logic [7:0]       shadow_d [NREGS];
    logic [NREGS-1:0] dirty_q, dirty_d;
`endif

    // Next-state and datapath: one event per cycle in fixed priority order.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        tx_byte_d   = tx_byte_q;
        tx_valid_d  = 1'b0;
        wr_strobe_d = '0;
        err_d       = err_q;
`ifdef I2C_REGBANK_SHADOW_EN
        shadow_d    = shadow_q;
        dirty_d     = dirty_q;
`endif
        if (frame_start) begin
            // Pointer is kept so a repeated START can read from it.
            state_d = ST_PTR;
            err_d   = 1'b0;
        end else if (frame_stop) begin
            state_d = ST_IDLE;
`ifdef I2C_REGBANK_SHADOW_EN
            // Commit everything written since the last STOP in one cycle.
            regs_d      = shadow_q;
            wr_strobe_d = dirty_q;
            dirty_d     = '0;
`endif
        end else if (rx_valid) begin
            case (state_q)
                ST_PTR: begin
                    if ({1'b0, rx_byte} < NREGS_9) begin
                        ptr_d   = rx_byte[PW-1:0];
                        state_d = ST_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                    end
                end
                ST_DATA: begin
`ifdef I2C_REGBANK_SHADOW_EN
                    shadow_d[ptr_q] = rx_byte;
                    dirty_d[ptr_q]  = 1'b1;
`else
                    regs_d[ptr_q]      = rx_byte;
                    wr_strobe_d[ptr_q] = 1'b1;
`endif
                    ptr_d = ptr_q + PTR_ONE;
                end
                default: begin
                    // IDLE and DROP ignore received bytes.
                    state_d = state_q;
                end
            endcase
        end else if (tx_req) begin
            case (state_q)
                ST_PTR, ST_DATA: begin
`ifdef I2C_REGBANK_SHADOW_EN
                    tx_byte_d = shadow_q[ptr_q];
`else
                    tx_byte_d = regs_q[ptr_q];
`endif
                    tx_valid_d = 1'b1;
                    ptr_d      = ptr_q + PTR_ONE;
                    state_d    = ST_DATA;
                end
                ST_DROP: begin
                    tx_byte_d  = 8'hFF;
                    tx_valid_d = 1'b1;
                end
                default: begin
                    // IDLE: no read response.
                    tx_valid_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            regs_q      <= '{default: RSTVAL};
            tx_byte_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            wr_strobe_q <= '0;
            err_q       <= 1'b0;
`ifdef I2C_REGBANK_SHADOW_EN
            shadow_q    <= '{default: RSTVAL};
            dirty_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            regs_q      <= regs_d;
            tx_byte_q   <= tx_byte_d;
            tx_valid_q  <= tx_valid_d;
            wr_strobe_q <= wr_strobe_d;
            err_q       <= err_d;
`ifdef I2C_REGBANK_SHADOW_EN
            shadow_q    <= shadow_d;
            dirty_q     <= dirty_d;
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_out
            assign reg_out[8*gi +: 8] = regs_q[gi];
        end
    endgenerate

    assign tx_byte   = tx_byte_q;
    assign tx_valid  = tx_valid_q;
    assign wr_strobe = wr_strobe_q;
    assign err       = err_q;

endmodule

// File: tb/tb_i2c_regbank.sv
// Testbench for i2c_regbank (default build, NREGS=8, RSTVAL=8'h00).
// A directed vector table covers the documented scenarios, then random
// traffic is compared against a frame-level reference model.
module tb_i2c_regbank;

    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst, frame_start, frame_stop, rx_valid, tx_req;
    logic [7:0]    rx_byte;
    logic [7:0]    tx_byte;
    logic          tx_valid;
    logic [NR*8-1:0] reg_out;
    logic [NR-1:0] wr_strobe;
    logic          err;

    int checks   = 0;
    int failures = 0;

    i2c_regbank #(.NREGS(NR), .RSTVAL(8'h00)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_stop(frame_stop),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_req(tx_req),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .reg_out(reg_out),
        .wr_strobe(wr_strobe), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Frame phases: 0 = no frame, 1 = awaiting pointer, 2 = transfer, 3 = dropping
    int         m_phase;
    int         m_ptr;
    logic [7:0] m_regs [NR];
    logic [7:0] m_txb;
    logic       m_txv;
    logic [7:0] m_stb;
    logic       m_err;

    task automatic model_step(input logic r, fs, fp, rv, input logic [7:0] rb, input logic tq);
        m_txv = 1'b0;
        m_stb = 8'h00;
        if (r) begin
            m_phase = 0; m_ptr = 0; m_txb = 8'h00; m_err = 1'b0;
            for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        end else if (fs) begin
            m_phase = 1; m_err = 1'b0;
        end else if (fp) begin
            m_phase = 0;
        end else if (rv) begin
            if (m_phase == 1) begin
                if (int'(rb) < NR) begin m_ptr = int'(rb); m_phase = 2; end
                else begin m_err = 1'b1; m_phase = 3; end
            end else if (m_phase == 2) begin
                m_regs[m_ptr] = rb;
                m_stb = 8'(1 << m_ptr);
                m_ptr = (m_ptr + 1) % NR;
            end
        end else if (tq) begin
            if (m_phase == 1 || m_phase == 2) begin
                m_txb = m_regs[m_ptr]; m_txv = 1'b1;
                m_ptr = (m_ptr + 1) % NR; m_phase = 2;
            end else if (m_phase == 3) begin
                m_txb = 8'hFF; m_txv = 1'b1;
            end
        end
    endtask

    function automatic logic [NR*8-1:0] model_regs();
        logic [NR*8-1:0] v;
        for (int i = 0; i < NR; i++) v[8*i +: 8] = m_regs[i];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic step(input logic r, fs, fp, rv, input logic [7:0] rb, input logic tq);
        rst = r; frame_start = fs; frame_stop = fp; rx_valid = rv; rx_byte = rb; tx_req = tq;
        @(posedge clk);
        #1;
        model_step(r, fs, fp, rv, rb, tq);
    endtask

    typedef struct {
        logic rst, fs, fp, rv;
        logic [7:0] rb;
        logic tq;
        logic etxv;
        logic [7:0] etxb;
        logic [7:0] estb;
        logic eerr;
    } vec_t;

    vec_t vecs [$];

    initial begin
        rst = 1'b1; frame_start = 1'b0; frame_stop = 1'b0;
        rx_valid = 1'b0; rx_byte = 8'h00; tx_req = 1'b0;

        // rst fs fp rv rb tq | txv txb stb err
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,1'b0}); // start
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h02,1'b0, 1'b0,8'h00,8'h00,1'b0}); // ptr 2
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'hA5,1'b0, 1'b0,8'h00,8'h04,1'b0}); // reg2
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h3C,1'b0, 1'b0,8'h00,8'h08,1'b0}); // reg3
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,1'b0}); // stop
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,1'b0}); // start
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h07,1'b0, 1'b0,8'h00,8'h00,1'b0}); // ptr 7
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h11,1'b0, 1'b0,8'h00,8'h80,1'b0}); // reg7
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h22,1'b0, 1'b0,8'h00,8'h01,1'b0}); // wrap reg0
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,1'b0}); // stop
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,1'b0}); // start
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h01,1'b0, 1'b0,8'h00,8'h00,1'b0}); // ptr 1
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,1'b0}); // rep start
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,8'h00,8'h00,1'b0}); // rd reg1
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,8'hA5,8'h00,1'b0}); // rd reg2
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,8'h3C,8'h00,1'b0}); // rd reg3
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0, 1'b0,8'h3C,8'h00,1'b0}); // stop, hold
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h3C,8'h00,1'b0}); // start
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h08,1'b0, 1'b0,8'h3C,8'h00,1'b1}); // bad ptr
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h55,1'b0, 1'b0,8'h3C,8'h00,1'b1}); // dropped
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,8'hFF,8'h00,1'b1}); // rd FF
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,8'hFF,8'h00,1'b0}); // err clr
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h03,1'b0, 1'b0,8'hFF,8'h00,1'b0}); // ptr 3
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h77,1'b0, 1'b0,8'hFF,8'h08,1'b0}); // reg3
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,1'b0}); // rst mid
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h99,1'b0, 1'b0,8'h00,8'h00,1'b0}); // ignored
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,1'b0}); // ignored
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,8'h44,1'b0, 1'b0,8'h00,8'h00,1'b0}); // fs+rv
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h05,1'b0, 1'b0,8'h00,8'h00,1'b0}); // ptr 5
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,8'h6B,1'b0, 1'b0,8'h00,8'h20,1'b0}); // reg5
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,1'b0}); // stop

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("reset_reg_out", 64'(reg_out), 64'h0);
        chk("reset_tx_valid", 64'(tx_valid), 64'h0);
        chk("reset_tx_byte", 64'(tx_byte), 64'h0);
        chk("reset_wr_strobe", 64'(wr_strobe), 64'h0);
        chk("reset_err", 64'(err), 64'h0);

        // Directed table.
        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].fs, vecs[k].fp, vecs[k].rv, vecs[k].rb, vecs[k].tq);
            chk($sformatf("vec%0d_tx_valid", k), 64'(tx_valid), 64'(vecs[k].etxv));
            chk($sformatf("vec%0d_tx_byte", k), 64'(tx_byte), 64'(vecs[k].etxb));
            chk($sformatf("vec%0d_wr_strobe", k), 64'(wr_strobe), 64'(vecs[k].estb));
            chk($sformatf("vec%0d_err", k), 64'(err), 64'(vecs[k].eerr));
            chk($sformatf("vec%0d_reg_out", k), 64'(reg_out), 64'(model_regs()));
        end
        // Spot check of the final register image from the scenarios.
        chk("final_reg5", 64'(reg_out[47:40]), 64'h6B);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic r, fs, fp, rv, tq;
            logic [7:0] rb;
            r  = ($urandom_range(0, 299) == 0);
            fs = ($urandom_range(0, 14) == 0);
            fp = ($urandom_range(0, 19) == 0);
            rv = ($urandom_range(0, 2) == 0);
            tq = ($urandom_range(0, 2) == 0);
            rb = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, NR - 1));
            step(r, fs, fp, rv, rb, tq);
            chk("rnd_reg_out", 64'(reg_out), 64'(model_regs()));
            chk("rnd_tx_valid", 64'(tx_valid), 64'(m_txv));
            chk("rnd_tx_byte", 64'(tx_byte), 64'(m_txb));
            chk("rnd_wr_strobe", 64'(wr_strobe), 64'(m_stb));
            chk("rnd_err", 64'(err), 64'(m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
